// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and helpers for the sequential multiplier
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_addshift_step.sv
// rtl/mult_addshift_step.sv - one conditional-add and right-shift step of the multiplier
module mult_addshift_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_mplier,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_mplier
);

    logic [WIDTH:0] w_sum;

    // WIDTH+1-bit adder keeps the carry; it shifts into the accumulator MSB.
    assign w_sum    = {1'b0, i_acc} + (i_mplier[0] ? {1'b0, i_mcand} : {(WIDTH+1){1'b0}});
    assign o_acc    = w_sum[WIDTH:1];
    assign o_mplier = {w_sum[0], i_mplier[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier_nxn.sv
// rtl/seq_multiplier_nxn.sv - WIDTH x WIDTH shift-add multiplier with signed mode and handshakes
module seq_multiplier_nxn
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_signed_mode,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_mcand;
    logic                 r_neg;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]     w_mplier_next;
    logic [2*WIDTH-1:0]   w_full;
    logic [2*WIDTH-1:0]   w_full_neg;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
    assign w_a_mag = (i_signed_mode && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag = (i_signed_mode && i_b[WIDTH-1]) ? -i_b : i_b;

    mult_addshift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc    (r_acc),
        .i_mplier (r_mplier),
        .i_mcand  (r_mcand),
        .o_acc    (w_acc_next),
        .o_mplier (w_mplier_next)
    );

    assign w_full     = {w_acc_next, w_mplier_next};
    assign w_full_neg = -w_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_mcand     <= '0;
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid && r_in_ready) begin
                        r_mcand    <= w_a_mag;
                        r_mplier   <= w_b_mag;
                        r_neg      <= i_signed_mode & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + CW'(1);
                    // The final step's result goes straight into the output register.
                    if (r_cnt == LAST_ITER) begin
                        r_product   <= r_neg ? w_full_neg : w_full;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_product   = r_product;

endmodule

// File: tb/tb_seq_multiplier_nxn.sv
// tb/tb_seq_multiplier_nxn.sv - self-checking bench for seq_multiplier_nxn at WIDTH 4 and 8
module tb_seq_multiplier_nxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v4, s4, or4;
    logic [3:0] a4, b4;
    logic       ir4, ov4;
    logic [7:0] p4;
    logic       v8, s8, or8;
    logic [7:0] a8, b8;
    logic       ir8, ov8;
    logic [15:0] p8;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [15:0] q4[$];
    logic [15:0] q8[$];

    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier_nxn #(.WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v4), .o_in_ready(ir4),
        .i_a(a4), .i_b(b4), .i_signed_mode(s4), .o_out_valid(ov4),
        .i_out_ready(or4), .o_product(p4)
    );

    seq_multiplier_nxn #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v8), .o_in_ready(ir8),
        .i_a(a8), .i_b(b8), .i_signed_mode(s8), .o_out_valid(ov8),
        .i_out_ready(or8), .o_product(p8)
    );

    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a, input logic [7:0] b, input logic s);
        longint ia, ib, pr;
        ia = longint'(a);
        ib = longint'(b);
        if (s && a[w-1]) ia = ia - (longint'(1) << w);
        if (s && b[w-1]) ib = ib - (longint'(1) << w);
        pr = ia * ib;
        return 16'(pr & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic txn4(input logic [3:0] a, input logic [3:0] b, input logic s, input int stall,
                        output logic [7:0] got, output int lat, output int acc_cyc, output bit ok);
        int n;
        ok = 1'b1; lat = 0; got = '0; acc_cyc = 0;
        n = 0;
        while (!ir4 && n < 50) begin @(negedge clk); n++; end
        if (!ir4) begin ok = 1'b0; return; end
        a4 = a; b4 = b; s4 = s; v4 = 1'b1; or4 = 1'b0; acc_cyc = cyc;
        q4.push_back(ref_mul(4, {4'b0, a}, {4'b0, b}, s));
        @(negedge clk);
        v4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
        lat = 1;
        while (!ov4 && lat < 50) begin @(negedge clk); lat++; end
        if (!ov4) begin ok = 1'b0; return; end
        repeat (stall) @(negedge clk);
        got = p4; or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
    endtask

    task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic s, input int stall,
                        output logic [15:0] got, output bit ok);
        int n;
        ok = 1'b1; got = '0;
        n = 0;
        while (!ir8 && n < 50) begin @(negedge clk); n++; end
        if (!ir8) begin ok = 1'b0; return; end
        a8 = a; b8 = b; s8 = s; v8 = 1'b1; or8 = 1'b0;
        q8.push_back(ref_mul(8, a, b, s));
        @(negedge clk);
        v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        n = 1;
        while (!ov8 && n < 50) begin @(negedge clk); n++; end
        if (!ov8) begin ok = 1'b0; return; end
        repeat (stall) @(negedge clk);
        got = p8; or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready4 got=%b exp=1", ir4); end
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid4 got=%b exp=0", ov4); end
        checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL reset_product4 got=%h exp=00", p4); end
        checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 16'h0) begin
            errors++; $display("FAIL reset_dut8 ir=%b ov=%b p=%h exp ir=1 ov=0 p=0000", ir8, ov8, p8);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [12:0] tbl[8];
        logic [7:0] got, exp_c;
        logic [15:0] exp_m;
        int lat, ac;
        bit ok;
        // {mode, a, b, expected product}
        tbl[0] = {1'b0, 4'hF, 4'hF, 4'h0}; tbl[1] = {1'b1, 4'h8, 4'h8, 4'h0};
        tbl[2] = {1'b1, 4'hD, 4'h5, 4'h0}; tbl[3] = {1'b0, 4'h0, 4'hF, 4'h0};
        tbl[4] = {1'b1, 4'h0, 4'hF, 4'h0}; tbl[5] = {1'b0, 4'h1, 4'hB, 4'h0};
        tbl[6] = {1'b1, 4'h1, 4'hB, 4'h0}; tbl[7] = {1'b1, 4'h7, 4'h9, 4'h0};
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: exp_c = 8'hE1; 1: exp_c = 8'h40; 2: exp_c = 8'hF1; 3: exp_c = 8'h00;
                4: exp_c = 8'h00; 5: exp_c = 8'h0B; default: exp_c = 8'hFB;
            endcase
            txn4(tbl[i][11:8], tbl[i][7:4], tbl[i][12], 0, got, lat, ac, ok);
            exp_m = (q4.size() > 0) ? q4.pop_front() : 16'hxxxx;
            checks++; if (!ok) begin errors++; $display("FAIL directed_timeout idx=%0d", i); end
            checks++; if (got !== exp_c) begin errors++; $display("FAIL directed_const idx=%0d got=%h exp=%h", i, got, exp_c); end
            checks++; if (got !== exp_m[7:0]) begin errors++; $display("FAIL directed_model idx=%0d got=%h exp=%h", i, got, exp_m[7:0]); end
            checks++; if (lat !== 5) begin errors++; $display("FAIL directed_latency idx=%0d got=%0d exp=5", i, lat); end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] got;
        int lat, ac;
        bit ok;
        int n;
        a4 = 4'd6; b4 = 4'd7; s4 = 1'b0; v4 = 1'b1; or4 = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        n = 0;
        while (!ov4 && n < 50) begin @(negedge clk); n++; end
        checks++; if (!ov4) begin errors++; $display("FAIL bp_timeout ov=%b exp=1", ov4); end
        a4 = 4'd3; b4 = 4'd3; v4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (p4 !== 8'd42 || ov4 !== 1'b1 || ir4 !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d p=%h ov=%b ir=%b exp p=2a ov=1 ir=0", i, p4, ov4, ir4);
            end
        end
        v4 = 1'b0; or4 = 1'b1;
        checks++; if (ir4 !== 1'b0) begin errors++; $display("FAIL bp_release_same got=%b exp=0", ir4); end
        @(negedge clk);
        or4 = 1'b0;
        checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0) begin errors++; $display("FAIL bp_release_next ir=%b ov=%b exp ir=1 ov=0", ir4, ov4); end
        repeat (7) @(negedge clk);
        checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin errors++; $display("FAIL bp_no_accept ov=%b ir=%b exp ov=0 ir=1", ov4, ir4); end
        txn4(4'd2, 4'd3, 1'b0, 0, got, lat, ac, ok);
        checks++; if (!ok || got !== q4.pop_front()) begin errors++; $display("FAIL bp_after got=%h exp=06", got); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        int lat, c0, c1;
        bit ok0, ok1;
        txn4(4'd3, 4'd4, 1'b0, 0, got, lat, c0, ok0);
        void'(q4.pop_front());
        txn4(4'd5, 4'd3, 1'b0, 0, got, lat, c1, ok1);
        checks++; if (!ok0 || !ok1 || got !== q4.pop_front()) begin errors++; $display("FAIL b2b_product got=%h exp=0f", got); end
        checks++; if (c1 - c0 !== 6) begin errors++; $display("FAIL b2b_period got=%0d exp=6", c1 - c0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int lat, ac;
        bit ok;
        a4 = 4'd5; b4 = 4'd5; s4 = 1'b0; v4 = 1'b1; or4 = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ov4 !== 1'b0 || p4 !== 8'h00 || ir4 !== 1'b1) begin
            errors++; $display("FAIL reset_mid ov=%b p=%h ir=%b exp ov=0 p=00 ir=1", ov4, p4, ir4);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_mid_stray ov=%b exp=0", ov4); end
        txn4(4'd7, 4'd9, 1'b0, 0, got, lat, ac, ok);
        void'(q4.pop_front());
        checks++; if (!ok || got !== 8'd63) begin errors++; $display("FAIL reset_mid_fresh got=%h exp=3f", got); end
    endtask

    task automatic test_exhaustive4();
        logic [7:0] got;
        logic [15:0] e;
        int lat, ac;
        bit ok;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    txn4(4'(a), 4'(b), 1'(s), $urandom_range(0, 2), got, lat, ac, ok);
                    e = (q4.size() > 0) ? q4.pop_front() : 16'hxxxx;
                    checks++; if (!ok || got !== e[7:0]) begin
                        errors++; $display("FAIL exh4 s=%0d a=%0d b=%0d got=%h exp=%h", s, a, b, got, e[7:0]);
                    end
                end
    endtask

    task automatic test_random8();
        logic [15:0] got, e;
        bit ok;
        for (int i = 0; i < 2500; i++) begin
            txn8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2), got, ok);
            e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
            checks++; if (!ok || got !== e) begin
                errors++; $display("FAIL rand8 idx=%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0; s4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
        v8 = 1'b0; s8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive4();
        test_random8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
